// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, frame-buffer geometry and pixel type
// used by the display-side frame reader.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned IMG_W    = 320;
    localparam int unsigned IMG_H    = 240;

    typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/vga_frame_reader_sync_counter.sv
// Wrap-around counter 0..TERMINAL with clock enable; carry flags the terminal
// count so a cascaded counter can advance on the wrap.
module sync_counter #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned TERMINAL = 799
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] TC = WIDTH'(TERMINAL);

    assign carry = (count == TC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= carry ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// VGA read engine: walks the frame buffer with 2x pixel doubling and drives
// RGB and syncs aligned to one-cycle synchronous RAM read latency.
module vga_frame_reader #(
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter int unsigned IMG_W    = vga_timing_pkg::IMG_W,
    parameter int unsigned IMG_H    = vga_timing_pkg::IMG_H,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  vga_timing_pkg::rgb12_t rd_data,
    output vga_timing_pkg::rgb12_t rgb_out,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   blank_n,
    output logic                   frame_start
);

    import vga_timing_pkg::*;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST_VIS = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_LO  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_HI  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_LO  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_HI  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    // Stage 0: raster position
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_wrap;
    logic          v_wrap;
    logic          v_en;

    assign v_en = en & h_wrap;

    sync_counter #(.WIDTH(HW), .TERMINAL(H_TOTAL - 1)) u_h_counter (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .count (h),
        .carry (h_wrap)
    );

    sync_counter #(.WIDTH(VW), .TERMINAL(V_TOTAL - 1)) u_v_counter (
        .clk   (clk),
        .reset (reset),
        .en    (v_en),
        .count (v),
        .carry (v_wrap)
    );

    logic visible;
    logic line_end;
    logic frame_end;

    assign visible   = (h < H_ACT) && (v < V_ACT);
    assign line_end  = visible && (h == H_LAST_VIS);
    assign frame_end = h_wrap && v_wrap;

    // Stage 1: addr tracks the pixel under the counter; rd_addr is its
    // registered copy, one en-cycle behind the raster position.
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] row_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            row_base <= '0;
            rd_addr  <= '0;
        end else if (en) begin
            rd_addr <= addr;
            if (frame_end) begin
                addr     <= '0;
                row_base <= '0;
            end else if (line_end) begin
                if (!v[0]) begin
                    addr <= row_base;
                end else if (addr != LAST_ADDR) begin
                    // Final buffer line holds at LAST_ADDR through blanking.
                    row_base <= addr + 1'b1;
                    addr     <= addr + 1'b1;
                end
            end else if (visible && h[0]) begin
                addr <= addr + 1'b1;
            end
        end
    end

    logic s1_valid;
    logic s1_blank_n;
    logic s1_hsync;
    logic s1_vsync;
    logic s1_fs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_blank_n <= 1'b0;
            s1_hsync   <= 1'b1;
            s1_vsync   <= 1'b1;
            s1_fs      <= 1'b0;
        end else if (en) begin
            s1_valid   <= 1'b1;
            s1_blank_n <= visible;
            s1_hsync   <= !((h >= H_SYNC_LO) && (h < H_SYNC_HI));
            s1_vsync   <= !((v >= V_SYNC_LO) && (v < V_SYNC_HI));
            s1_fs      <= (h == '0) && (v == '0);
        end
    end

    // Stage 2: aligned with rd_data; frame_start is a single en-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_n     <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else if (en) begin
            blank_n     <= s1_valid & s1_blank_n;
            hsync       <= !s1_valid | s1_hsync;
            vsync       <= !s1_valid | s1_vsync;
            frame_start <= s1_valid & s1_fs;
        end else begin
            frame_start <= 1'b0;
        end
    end

    assign rgb_out = blank_n ? rd_data : '0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a reduced raster (24x12 total,
// 16x8 visible, 8x4 buffer) so whole frames fit in a short run.
module tb_vga_frame_reader;

    localparam int HA = 16, HF = 2, HS = 4, HB = 2, HT = HA + HF + HS + HB;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
    localparam int IW = 8,  IH = 4;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [16:0] rd_addr;
    logic [11:0] rd_data = '0;
    logic [11:0] rgb_out;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        frame_start;
    logic        force_white;

    int tests = 0;
    int fails = 0;

    vga_frame_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .IMG_W    (IW), .IMG_H (IH), .ADDR_W (17)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rgb_out     (rgb_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_n     (blank_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Model RAM: data = addr[11:0], or all-ones when forced
    always @(posedge clk) begin
        if (en) rd_data <= force_white ? 12'hFFF : rd_addr[11:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic e);
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_rgb"}, 32'(rgb_out), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_blank_n"}, 32'(blank_n), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    // Outputs show pixel p; rd_addr shows the fetch for pixel p+1.
    task automatic check_pixel(input int p);
        int h, v, q, hq, vq;
        logic vis;
        logic [11:0] exp_rgb;
        h = p % HT;
        v = (p / HT) % VT;
        vis = (h < HA) && (v < VA);
        exp_rgb = !vis ? 12'h000 : (force_white ? 12'hFFF : 12'((v / 2) * IW + h / 2));
        check("blank_n", 32'(blank_n), 32'(vis));
        check("hsync", 32'(hsync), 32'(!(h >= HA + HF && h < HA + HF + HS)));
        check("vsync", 32'(vsync), 32'(!(v >= VA + VF && v < VA + VF + VS)));
        check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
        check("rgb", 32'(rgb_out), 32'(exp_rgb));
        q = p + 1;
        hq = q % HT;
        vq = (q / HT) % VT;
        if (hq < HA && vq < VA) check("rd_addr", 32'(rd_addr), 32'((vq / 2) * IW + hq / 2));
        check("rd_addr_max", 32'(rd_addr <= 17'(IW * IH - 1)), 32'd1);
    endtask

    task automatic restart;
        reset = 1'b1;
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int first_fs, second_fs;
        logic [11:0] p_rgb;
        logic [16:0] p_addr;
        logic p_hs, p_vs, p_bn;

        force_white = 1'b0;
        reset = 1'b1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // First en-cycle: pipeline not yet filled
        tick(1'b1);
        check("fill_frame_start", 32'(frame_start), 32'd0);
        check("fill_blank_n", 32'(blank_n), 32'd0);
        check("fill_rd_addr", 32'(rd_addr), 32'd0);

        // Two full frames plus the start of a third
        for (int p = 0; p <= 2 * FRAME + 2; p++) begin
            if (p > 0) tick(1'b1);
            else tick(1'b1);
            check_pixel(p);
            if (p == 2)            check("line0_px2", 32'(rgb_out), 32'd1);
            if (p == HT + 3)       check("line1_px3", 32'(rgb_out), 32'd1);
            if (p == 2 * HT)       check("line2_px0", 32'(rgb_out), 32'd8);
            if (p == 7 * HT + 15)  check("last_px", 32'(rgb_out), 32'd31);
            if (p == FRAME - 1)    check("next_fetch", 32'(rd_addr), 32'd0);
        end

        // en toggling: frame period doubles, outputs hold on idle cycles
        restart();
        first_fs = -1;
        second_fs = -1;
        for (int k = 0; k < 4 * FRAME; k++) begin
            p_rgb = rgb_out; p_addr = rd_addr;
            p_hs = hsync; p_vs = vsync; p_bn = blank_n;
            tick(k % 2 == 0);
            if (k % 2 != 0) begin
                check("hold_rgb", 32'(rgb_out), 32'(p_rgb));
                check("hold_rd_addr", 32'(rd_addr), 32'(p_addr));
                check("hold_syncs", 32'({hsync, vsync, blank_n}), 32'({p_hs, p_vs, p_bn}));
                check("hold_frame_start", 32'(frame_start), 32'd0);
            end
            if (frame_start) begin
                if (first_fs < 0) first_fs = k;
                else if (second_fs < 0) second_fs = k;
            end
        end
        check("toggle_first_fs", 32'(first_fs), 32'd2);
        check("toggle_period", 32'(second_fs - first_fs), 32'(2 * FRAME));

        // Reset mid-frame with counter at (10,5)
        restart();
        for (int n = 0; n < 5 * HT + 10; n++) tick(1'b1);
        check("pre_reset_blank_n", 32'(blank_n), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("held_reset");
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1);
        check("rst_fill_frame_start", 32'(frame_start), 32'd0);
        check("rst_fill_rd_addr", 32'(rd_addr), 32'd0);
        for (int p = 0; p < 3 * HT; p++) begin
            tick(1'b1);
            check_pixel(p);
        end

        // Saturated data: rgb follows blank_n exactly
        force_white = 1'b1;
        restart();
        tick(1'b1);
        for (int p = 0; p < FRAME; p++) begin
            tick(1'b1);
            check_pixel(p);
            check("white_gate", 32'(rgb_out), blank_n ? 32'hFFF : 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Display-side read engine for the camera frame buffer. Generates 640×480@60 VGA timing, walks the 320×240 buffer with 2× horizontal and vertical pixel doubling, and drives 12-bit RGB plus syncs aligned to synchronous-RAM read latency. It is the reader counterpart to the capture path's write-address counter: capture writes the buffer linearly, this block reads it back linearly.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (V_TOTAL = 525)
- IMG_W, 320, buffer pixels per line
- IMG_H, 240, buffer lines
- ADDR_W, 17, read address width (≥ clog2(IMG_W·IMG_H))

Ports:
- clk, in, 1, pixel-domain clock
- reset, in, 1, asynchronous, active-high
- en, in, 1, pixel clock enable; all state advances only when high
- rd_addr, out, ADDR_W, frame-buffer read address, registered
- rd_data, in, 12, RAM read data {R4,G4,B4}, valid one en-cycle after rd_addr
- rgb_out, out, 12, pixel to DAC; 0 when blanked
- hsync, out, 1, active-low horizontal sync
- vsync, out, 1, active-low vertical sync
- blank_n, out, 1, high during visible region
- frame_start, out, 1, one en-cycle pulse coinciding with output pixel (0,0)

## Operation
- Stage 0: h counter 0..H_TOTAL-1 wraps to 0; v increments on h wrap, 0..V_TOTAL-1 wraps to 0.
- Stage 1 (rd_addr): incremental, no multiplier. Internal row_base register.
  - In the visible region, addr increments on odd h (h[0]=1), i.e. once per two screen pixels.
  - At h = H_ACTIVE-1 on a visible line: if v[0]=0, addr ← row_base (repeat the buffer line); if v[0]=1, row_base ← addr+1 and addr ← addr+1 (advance).
  - At v = V_TOTAL-1, h = H_TOTAL-1: addr ← 0, row_base ← 0.
  - Outside the visible region, addr holds.
- Stage 2 (outputs): blank_n = (h<H_ACTIVE && v<V_ACTIVE); hsync = !(H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC); vsync likewise on v. All are delayed two en-cycles to align with rd_data. rgb_out = blank_n ? rd_data : 0.
- Last visible pixel reads address IMG_W·IMG_H-1 = 76799. The address never exceeds this value.
- en low: counters, address, pipeline and outputs hold; frame_start stays at 0.

## Timing
- Reset values: h=v=0, rd_addr=0, row_base=0, rgb_out=0, hsync=1, vsync=1, blank_n=0, frame_start=0, pipeline valid bits cleared.
- Latency: counter position (h,v) appears at outputs 2 en-cycles later. rd_addr for (h,v) is presented 1 en-cycle after the counter.
- The first frame after reset starts with frame_start two en-cycles after the first en. Pipeline stages not yet filled output blank values.
- Reset asserted mid-frame: all state returns to reset values immediately. The frame restarts at (0,0) with address 0. No partial-line recovery.
- Simultaneous h and v wrap: both counters go to 0 in the same cycle, and the address reset takes priority over line repeat/advance.

## Structure
- Package vga_timing_pkg: timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL), IMG_W/IMG_H, and the rgb12 pixel typedef.
- Sub-module sync_counter: a wrap-around counter parameterised by width and terminal count, with en input and carry-out. Instantiated twice; the h carry-out, ANDed with en, drives the v enable.
- Address generator, sync decode and output pipeline stay in the top level.

## Test plan
- Reset then en=1 continuously: frame_start pulses every 420000 cycles; hsync low for 96 cycles per 800-cycle period; vsync low for 2 lines (1600 cycles) per frame.
- rd_data driven with a model RAM holding data = addr[11:0]: output line 0 repeats each value twice (0,0,1,1,…,319,319); line 1 is identical to line 0; line 2 starts at 320.
- Last visible pixel (639,479): rgb_out shows the data of address 76799. The next frame's first fetch address is 0.
- en toggled 1,0,1,0: frame period doubles to 840000 clk cycles and outputs hold on en=0 cycles.
- Reset asserted at (h=300, v=200) for 3 cycles: outputs return to reset values on the same edge. After release, rd_addr=0 and frame_start fires two en-cycles after the first en.
- Blank region: with rd_data forced to 12'hFFF, rgb_out=0 whenever blank_n=0 and rgb_out=12'hFFF whenever blank_n=1.
